// File: rtl/op_amp_pkg.sv
// op_amp_pkg: shared widths, code types and the Q8.8 round-and-clip helper for op_amp_frac_rms
package op_amp_pkg;
  localparam int IN_W = 16;
  localparam int OUT_W = 32;
  localparam int Q_FRAC = 8;
  typedef logic [15:0] code_t;
  typedef logic [15:0] gain_q8_8_t;
  function automatic code_t sat_round_q8(input logic [31:0] prod, input code_t rail);
    logic [32:0] t;
    t = ({1'b0, prod} + 33'd128) >> Q_FRAC;
    return (t > {17'b0, rail}) ? rail : t[15:0];
  endfunction
endpackage

// File: rtl/op_amp_frac_rms_clk_div_tick.sv
// clk_div_tick: divides clk by DIV into a 50% duty clk_100k and a one-cycle tick on its falling phase
module clk_div_tick #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_100k,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  logic [CW-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      clk_100k <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick || cnt == HALF) clk_100k <= ~clk_100k;
    end
endmodule

// File: rtl/op_amp_frac_rms.sv
// op_amp_frac_rms: fractional-gain op-amp model sampled per tick with squared output; OPAMP_SLEW_LIMIT_EN adds slew limiting
module op_amp_frac_rms
  import op_amp_pkg::*;
#(
  parameter int         DIV    = 1000,
  parameter gain_q8_8_t GAIN_Q = 16'h0A80,
  parameter code_t      RAIL   = 16'hFFFF,
  parameter code_t      SLEW   = 16'd64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IN_W-1:0]    non_inv,
  output logic [OUT_W-1:0]   square_out,
  output logic               clk_100k
);
  logic  tick, tick_d;
  code_t vout, target, nxt;
  clk_div_tick #(.DIV(DIV)) u_div (.clk(clk), .rst(reset_n), .clk_100k(clk_100k), .tick(tick));
  assign target = sat_round_q8({16'b0, non_inv} * {16'b0, GAIN_Q}, RAIL);
`ifdef OPAMP_SLEW_LIMIT_EN
  code_t up, dn;
  always_comb begin
    up  = target - vout;
    dn  = vout - target;
    nxt = (target > vout) ? vout + ((up > SLEW) ? SLEW : up)
                          : vout - ((dn > SLEW) ? SLEW : dn);
  end
`else
  assign nxt = target;
`endif
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) begin
      vout <= '0;
      tick_d <= 1'b0;
      square_out <= '0;
    end else begin
      tick_d <= tick;
      if (tick) vout <= nxt;
      if (tick_d) square_out <= {16'b0, vout} * {16'b0, vout};
    end
endmodule

// File: tb/tb_op_amp_frac_rms.sv
// tb_op_amp_frac_rms: randomized self-checking bench against a per-tick arithmetic model of the amplifier
module tb_op_amp_frac_rms;
  localparam int DIV = 1000;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] non_inv = '0;
  logic [31:0] square_out;
  logic        clk_100k;
  int checks = 0, failures = 0;
  int edges, last_tick;
  longint mv;

  op_amp_frac_rms dut (.clk(clk), .reset_n(reset_n), .non_inv(non_inv),
                       .square_out(square_out), .clk_100k(clk_100k));

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset_n)
    if (reset_n) edges <= 0;
    else edges <= edges + 1;

  function automatic longint model(input longint v, input longint n);
    longint t;
    t = (n * 2688 + 128) / 256;
    if (t > 65535) t = 65535;
`ifdef OPAMP_SLEW_LIMIT_EN
    if (t > v) return v + ((t - v) < 64 ? (t - v) : 64);
    return v - ((v - t) < 64 ? (v - t) : 64);
`else
    return t;
`endif
  endfunction

  task automatic wait_edges(input int n);
    int guard = 0;
    while (edges < n) begin
      @(posedge clk);
      #1;
      if (++guard > 5000) begin
        failures++;
        $display("FAIL wait_edges edges=%0d required=%0d", edges, n);
        break;
      end
    end
  endtask

  task automatic step_ticks(input int cnt);
    longint prev;
    int kt;
    for (int i = 0; i < cnt; i++) begin
      kt = last_tick + 1;
      wait_edges(DIV * (kt - 1) + DIV / 2 - 1);
      checks++;
      if (clk_100k !== 1'b0) begin
        failures++;
        $display("FAIL clk_low tick=%0d got=%b want=0", kt, clk_100k);
      end
      wait_edges(DIV * (kt - 1) + DIV / 2);
      checks++;
      if (clk_100k !== 1'b1) begin
        failures++;
        $display("FAIL clk_rise tick=%0d got=%b want=1", kt, clk_100k);
      end
      prev = mv;
      wait_edges(DIV * kt);
      mv = model(mv, longint'(non_inv));
      checks++;
      if (square_out !== 32'(prev * prev)) begin
        failures++;
        $display("FAIL hold tick=%0d got=%0d want=%0d", kt, square_out, prev * prev);
      end
      wait_edges(DIV * kt + 1);
      checks++;
      if (square_out !== 32'(mv * mv) || clk_100k !== 1'b0) begin
        failures++;
        $display("FAIL square tick=%0d got=%0d clk=%b want=%0d clk=0", kt, square_out, clk_100k, mv * mv);
      end
      last_tick = kt;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    #3;
    checks++;
    if (square_out !== 32'd0 || clk_100k !== 1'b0) begin
      failures++;
      $display("FAIL reset square=%0d clk=%b want 0/0", square_out, clk_100k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    mv = 0;
    last_tick = 0;
  endtask

  task automatic test_reset();
    non_inv = 16'd7;
    do_reset();
  endtask

  task automatic test_small();
    step_ticks(1);
`ifndef OPAMP_SLEW_LIMIT_EN
    checks++;
    if (square_out !== 32'd5476) begin
      failures++;
      $display("FAIL small got=%0d want=5476", square_out);
    end
`endif
  endtask

  task automatic test_mid();
    non_inv = 16'd100;
    step_ticks(20);
    checks++;
    if (square_out !== 32'd1102500) begin
      failures++;
      $display("FAIL mid got=%0d want=1102500", square_out);
    end
  endtask

  task automatic test_clip();
    non_inv = 16'd62200;
    step_ticks(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      non_inv = 16'($urandom);
      wait_edges(DIV * last_tick + 250);
      non_inv = 16'($urandom);
      checks++;
      if (square_out !== 32'(mv * mv)) begin
        failures++;
        $display("FAIL ignore_change got=%0d want=%0d", square_out, mv * mv);
      end
      step_ticks(2);
    end
  endtask

  task automatic test_reset_mid();
    non_inv = 16'd2200;
    step_ticks(2);
    wait_edges(DIV * last_tick + 700);
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (square_out !== 32'd0 || clk_100k !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid square=%0d clk=%b want 0/0", square_out, clk_100k);
    end
    do_reset();
    step_ticks(1);
`ifndef OPAMP_SLEW_LIMIT_EN
    checks++;
    if (square_out !== 32'd533610000) begin
      failures++;
      $display("FAIL reset_release got=%0d want=533610000", square_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_small();
    test_mid();
    test_clip();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
